// File: rtl/out_capture_fifo_if.sv
// Port bundle for out_capture_fifo: CPU output strobe, host pop handshake and status.
// Macro OUT_CAPTURE_STAMP_EN adds the rd_stamp signal.
interface out_capture_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] O;
    logic             OEnable;
    logic             clear;
    logic             pop;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic [15:0]      total;
`ifdef OUT_CAPTURE_STAMP_EN
    logic [15:0]      rd_stamp;
`endif

    // Each OEnable-high cycle is one push. A pop sampled with empty low is
    // accepted; rd_data/rd_valid answer it one cycle later. A pop while empty is ignored.
`ifdef OUT_CAPTURE_STAMP_EN
    modport master (output O, OEnable, clear, pop,
                    input  rd_data, rd_valid, count, empty, full, overflow, total, rd_stamp);
    modport slave  (input  O, OEnable, clear, pop,
                    output rd_data, rd_valid, count, empty, full, overflow, total, rd_stamp);
`else
    modport master (output O, OEnable, clear, pop,
                    input  rd_data, rd_valid, count, empty, full, overflow, total);
    modport slave  (input  O, OEnable, clear, pop,
                    output rd_data, rd_valid, count, empty, full, overflow, total);
`endif
endinterface

// File: rtl/out_capture_fifo.sv
// Captures every CPU output byte strobed by OEnable into a FIFO drained by pop/rd_valid.
// Macro OUT_CAPTURE_STAMP_EN stores a 16-bit cycle stamp alongside each byte.
module out_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    out_capture_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      total_q, total_d;
    logic             pop_ok, push_ok, wr_en;

    // A full FIFO still accepts a push when the same cycle frees a slot.
    always_comb begin
        pop_ok     = bus.pop && !empty_q;
        push_ok    = bus.OEnable && (!full_q || pop_ok);
        wr_en      = push_ok && !bus.clear;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        empty_d    = empty_q;
        full_d     = full_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        total_d    = total_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            empty_d    = 1'b1;
            full_d     = 1'b0;
            overflow_d = 1'b0;
            total_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
            end else if (bus.OEnable) begin
                overflow_d = 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            empty_d = (count_d == '0);
            full_d  = (count_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            total_q    <= total_d;
        end
    end

    // Storage is deliberately not reset; the pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.O;
    end

`ifdef OUT_CAPTURE_STAMP_EN
    logic [15:0] stamp_mem_q [DEPTH];
    logic [15:0] cycle_q, cycle_d;
    logic [15:0] rd_stamp_q, rd_stamp_d;

    always_comb begin
        cycle_d    = bus.clear ? 16'd0 : cycle_q + 16'd1;
        rd_stamp_d = (pop_ok && !bus.clear) ? stamp_mem_q[rd_ptr_q] : rd_stamp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            rd_stamp_q <= '0;
        end else begin
            cycle_q    <= cycle_d;
            rd_stamp_q <= rd_stamp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) stamp_mem_q[wr_ptr_q] <= cycle_q;
    end

    assign bus.rd_stamp = rd_stamp_q;
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
    assign bus.total    = total_q;
endmodule

// File: tb/tb_out_capture_fifo.sv
// Directed bench for out_capture_fifo: a queue model predicts every output after each edge,
// and hand-computed constants pin the scenario end points.
module tb_out_capture_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    out_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    out_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    logic [WIDTH-1:0] exp_q [$];
    logic [15:0]      exp_s_q [$];
    logic [15:0]      m_total;
    logic             m_ovf;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [15:0]      m_cycle;
    logic [15:0]      m_stamp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_s_q.delete();
        m_total = '0;
        m_ovf   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_cycle = '0;
        m_stamp = '0;
    endtask

    task automatic check_reset_values();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_total", 32'(bus.total), 32'd0);
    endtask

    // One clock edge: apply inputs, advance the model, then compare every output.
    task automatic step(input bit oe, input logic [WIDTH-1:0] o, input bit pp, input bit clr);
        bit pop_ok, push_ok;
        bus.OEnable = oe;
        bus.O       = oe ? o : 'x;
        bus.pop     = pp;
        bus.clear   = clr;
        pop_ok  = pp && (exp_q.size() != 0);
        push_ok = oe && ((exp_q.size() < DEPTH) || pop_ok);
        if (clr) begin
            exp_q.delete();
            exp_s_q.delete();
            m_total = '0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = pop_ok;
            if (pop_ok) begin
                m_data  = exp_q.pop_front();
                m_stamp = exp_s_q.pop_front();
            end
            if (push_ok) begin
                exp_q.push_back(o);
                exp_s_q.push_back(m_cycle);
                if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
            end else if (oe) begin
                m_ovf = 1'b1;
            end
        end
        m_cycle = clr ? 16'd0 : m_cycle + 16'd1;
        @(posedge clk);
        #1;
        bus.OEnable = 1'b0;
        bus.O       = 'x;
        bus.pop     = 1'b0;
        bus.clear   = 1'b0;
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("rd_data", 32'(bus.rd_data), 32'(m_data));
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
        check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("total", 32'(bus.total), 32'(m_total));
`ifdef OUT_CAPTURE_STAMP_EN
        check("rd_stamp", 32'(bus.rd_stamp), 32'(m_stamp));
`endif
    endtask

    initial begin
        bus.O = '0;
        bus.OEnable = 1'b0;
        bus.pop = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        rst_n = 1'b1;
        #1;

        phase = "basic";
        step(1, 8'h10, 0, 0);
        step(1, 8'h11, 0, 0);
        step(1, 8'h12, 0, 0);
        check("count3", 32'(bus.count), 32'd3);
        step(0, 8'h00, 1, 0);
        check("first", 32'(bus.rd_data), 32'h10);
        step(0, 8'h00, 1, 0);
        check("second", 32'(bus.rd_data), 32'h11);
        step(0, 8'h00, 1, 0);
        check("third", 32'(bus.rd_data), 32'h12);
        check("empty_end", 32'(bus.empty), 32'd1);
        check("total3", 32'(bus.total), 32'd3);

        phase = "stream";
        for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0);
        check("full32", 32'(bus.full), 32'd1);
        check("no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 32; i++) step(0, 8'h00, 1, 0);

        phase = "ovf";
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd32);
        check("ovf_total", 32'(bus.total), 32'd32);
        for (int i = 0; i < 32; i++) step(0, 8'h00, 1, 0);
        check("last_not_aa", 32'(bus.rd_data), 32'd31);
        step(1, 8'hBB, 0, 0);
        step(0, 8'h00, 1, 0);
        check("bb_back", 32'(bus.rd_data), 32'hBB);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        phase = "bnd";
        step(0, 8'h00, 0, 1);
        step(1, 8'h55, 1, 0);
        check("no_bypass", 32'(bus.rd_valid), 32'd0);
        check("cnt1", 32'(bus.count), 32'd1);
        step(0, 8'h00, 1, 0);
        check("got55", 32'(bus.rd_data), 32'h55);
        for (int i = 0; i < 32; i++) step(1, 8'(8'h20 + i), 0, 0);
        step(1, 8'h66, 1, 0);
        check("old_head", 32'(bus.rd_data), 32'h20);
        check("full_cnt", 32'(bus.count), 32'd32);
        check("full_no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 32; i++) step(0, 8'h00, 1, 0);
        check("66_last", 32'(bus.rd_data), 32'h66);

        phase = "wrap";
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 40; i++)
            step(1, 8'(8'h80 + i), exp_q.size() >= (i % 3) + 1, 0);
        while (exp_q.size() != 0) step(0, 8'h00, 1, 0);
        check("wrap_last", 32'(bus.rd_data), 32'hA7);
        step(1, 8'h71, 0, 0);
        step(1, 8'h72, 0, 0);
        step(1, 8'h77, 0, 1);
        check("clr_count", 32'(bus.count), 32'd0);
        check("clr_total", 32'(bus.total), 32'd0);
        check("clr_ovf", 32'(bus.overflow), 32'd0);
        step(0, 8'h00, 1, 0);
        check("empty_pop", 32'(bus.rd_valid), 32'd0);
        step(1, 8'h88, 0, 0);
        step(0, 8'h00, 1, 0);
        check("not_77", 32'(bus.rd_data), 32'h88);

        phase = "areset";
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 0, 0);
        step(1, 8'hC3, 0, 0);
        step(0, 8'h00, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        #1;
        rst_n = 1'b1;
        step(1, 8'h01, 0, 0);
        step(0, 8'h00, 1, 0);
        check("got01", 32'(bus.rd_data), 32'h01);
        check("valid01", 32'(bus.rd_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
